// File: rtl/pcie_dllp_fc_init_tx.sv
// DLLP flow-control init transmitter: sends InitFC1 then InitFC2 sets (P, NP, Cpl).
// Define FC_INIT_RESEND_TIMER_EN to insert a RESEND_CYCLES idle gap between sets.
module pcie_dllp_fc_init_tx #(
  parameter logic [2:0] VC_ID         = 3'd0,
  parameter int         RESEND_CYCLES = 1024,
  parameter int         CNT_W         = $clog2(RESEND_CYCLES + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        phy_link_up_i,
  input  logic        init_flow_control_i,
  input  logic        fc1_values_stored_i,
  input  logic        fc2_values_stored_i,
  input  logic [7:0]  ph_credits_i,
  input  logic [11:0] pd_credits_i,
  input  logic [7:0]  nph_credits_i,
  input  logic [11:0] npd_credits_i,
  input  logic [7:0]  cplh_credits_i,
  input  logic [11:0] cpld_credits_i,
  output logic        dllp_valid_o,
  output logic [31:0] dllp_data_o,
  input  logic        dllp_ready_i,
  output logic [1:0]  fc_phase_o,
  output logic        fc_init_done_o
);

`ifdef FC_INIT_RESEND_TIMER_EN
  typedef enum logic [2:0] {ST_IDLE, ST_FC1, ST_FC2, ST_DONE, ST_FC1_WAIT, ST_FC2_WAIT} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_FC1, ST_FC2, ST_DONE} state_t;
`endif

  typedef struct packed {
    logic [7:0]  ph;
    logic [11:0] pd;
    logic [7:0]  nph;
    logic [11:0] npd;
    logic [7:0]  cplh;
    logic [11:0] cpld;
  } cred_t;

  if (RESEND_CYCLES < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("RESEND_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  phase_q, phase_d;
  logic        done_q, done_d;
  logic [1:0]  idx_q, idx_d;
  logic        fc1_seen_q, fc1_seen_d;
  logic        fc2_seen_q, fc2_seen_d;
  cred_t       cred_q, cred_d;
`ifdef FC_INIT_RESEND_TIMER_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic        fc1_active, fc2_active, seen;
  logic [7:0]  hdr_sel;
  logic [11:0] dat_sel;

  // Type byte {fc2, 1, idx, 0, VC}: 0x40/0x50/0x60 in FC1, 0xC0/0xD0/0xE0 in FC2.
  function automatic logic [31:0] make_word(input logic fc2, input logic [1:0] idx,
                                            input logic [7:0] hdr, input logic [11:0] dat);
    return {fc2, 1'b1, idx, 1'b0, VC_ID, 2'b00, hdr, 2'b00, dat};
  endfunction

  always_comb begin
    fc1_active = (state_q == ST_FC1);
    fc2_active = (state_q == ST_FC2);
`ifdef FC_INIT_RESEND_TIMER_EN
    fc1_active = fc1_active || (state_q == ST_FC1_WAIT);
    fc2_active = fc2_active || (state_q == ST_FC2_WAIT);
`endif
    seen = fc2_active ? (fc2_seen_q || fc2_values_stored_i)
                      : (fc1_seen_q || fc1_values_stored_i);
    case (idx_q)
      2'd0:    begin hdr_sel = cred_q.ph;   dat_sel = cred_q.pd;   end
      2'd1:    begin hdr_sel = cred_q.nph;  dat_sel = cred_q.npd;  end
      default: begin hdr_sel = cred_q.cplh; dat_sel = cred_q.cpld; end
    endcase
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    idx_d      = idx_q;
    fc1_seen_d = fc1_seen_q || (fc1_active && fc1_values_stored_i);
    fc2_seen_d = fc2_seen_q || (fc2_active && fc2_values_stored_i);
    cred_d     = cred_q;
`ifdef FC_INIT_RESEND_TIMER_EN
    cnt_d      = cnt_q;
`endif
    if (!phy_link_up_i) begin
      state_d    = ST_IDLE;
      valid_d    = 1'b0;
      idx_d      = 2'd0;
      fc1_seen_d = 1'b0;
      fc2_seen_d = 1'b0;
`ifdef FC_INIT_RESEND_TIMER_EN
      cnt_d      = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (init_flow_control_i) begin
          state_d = ST_FC1;
          idx_d   = 2'd0;
          cred_d  = '{ph: ph_credits_i, pd: pd_credits_i, nph: nph_credits_i,
                      npd: npd_credits_i, cplh: cplh_credits_i, cpld: cpld_credits_i};
        end
        ST_FC1, ST_FC2: begin
          if (!valid_q) begin
            valid_d = 1'b1;
            data_d  = make_word(fc2_active, idx_q, hdr_sel, dat_sel);
          end else if (dllp_ready_i) begin
            valid_d = 1'b0;
            if (idx_q == 2'd2) begin
              idx_d = 2'd0;
              if (seen) begin
                state_d = fc2_active ? ST_DONE : ST_FC2;
              end
`ifdef FC_INIT_RESEND_TIMER_EN
              else begin
                state_d = fc2_active ? ST_FC2_WAIT : ST_FC1_WAIT;
                cnt_d   = CNT_W'(RESEND_CYCLES - 1);
              end
`endif
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
`ifdef FC_INIT_RESEND_TIMER_EN
        // The restart word goes out on the last wait cycle so the gap is exactly RESEND_CYCLES.
        ST_FC1_WAIT, ST_FC2_WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (seen) begin
            state_d = fc2_active ? ST_DONE : ST_FC2;
          end else begin
            state_d = fc2_active ? ST_FC2 : ST_FC1;
            valid_d = 1'b1;
            data_d  = make_word(fc2_active, 2'd0, cred_q.ph, cred_q.pd);
          end
        end
`endif
        default: ;
      endcase
    end

    case (state_d)
      ST_IDLE: phase_d = 2'd0;
      ST_FC2:  phase_d = 2'd2;
      ST_DONE: phase_d = 2'd3;
`ifdef FC_INIT_RESEND_TIMER_EN
      ST_FC2_WAIT: phase_d = 2'd2;
`endif
      default: phase_d = 2'd1;
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      data_q     <= '0;
      phase_q    <= 2'd0;
      done_q     <= 1'b0;
      idx_q      <= 2'd0;
      fc1_seen_q <= 1'b0;
      fc2_seen_q <= 1'b0;
      cred_q     <= '0;
`ifdef FC_INIT_RESEND_TIMER_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      phase_q    <= phase_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      fc1_seen_q <= fc1_seen_d;
      fc2_seen_q <= fc2_seen_d;
      cred_q     <= cred_d;
`ifdef FC_INIT_RESEND_TIMER_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign dllp_valid_o   = valid_q;
  assign dllp_data_o    = data_q;
  assign fc_phase_o     = phase_q;
  assign fc_init_done_o = done_q;

endmodule

// File: tb/tb_pcie_dllp_fc_init_tx.sv
// Self-checking bench for pcie_dllp_fc_init_tx: vector table, directed corner cases,
// and randomized traffic against a word-stream reference model.
module tb_pcie_dllp_fc_init_tx;
  localparam int         RESEND = 16;
  localparam logic [2:0] VC     = 3'd0;

  localparam logic [31:0] P1 = 32'h40080100, NP1 = 32'h50040020, C1 = 32'h6000CABC;
  localparam logic [31:0] P2 = 32'hC0080100, NP2 = 32'hD0040020, C2 = 32'hE000CABC;

  logic        clk = 1'b0;
  logic        rst, link, init, s1, s2, ready;
  logic [7:0]  ph, nph, cplh;
  logic [11:0] pd, npd, cpld;
  logic        valid, done;
  logic [31:0] data;
  logic [1:0]  phase;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcie_dllp_fc_init_tx #(.VC_ID(VC), .RESEND_CYCLES(RESEND)) dut (
    .clk_i(clk), .rst_i(rst), .phy_link_up_i(link), .init_flow_control_i(init),
    .fc1_values_stored_i(s1), .fc2_values_stored_i(s2),
    .ph_credits_i(ph), .pd_credits_i(pd), .nph_credits_i(nph), .npd_credits_i(npd),
    .cplh_credits_i(cplh), .cpld_credits_i(cpld),
    .dllp_valid_o(valid), .dllp_data_o(data), .dllp_ready_i(ready),
    .fc_phase_o(phase), .fc_init_done_o(done)
  );

  typedef struct {
    logic        link, init, s1, s2, ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_phase;
    logic        exp_done;
  } vec_t;

  // Reference model: phase number, words accepted in this phase, gap countdown.
  int          m_phase, m_sent, m_gap;
  logic        m_valid, m_seen;
  logic [31:0] m_word;
  int          m_cred[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_creds();
    ph = 8'h20; pd = 12'h100; nph = 8'h10; npd = 12'h020; cplh = 8'h03; cpld = 12'hABC;
  endtask

  task automatic model_reset();
    m_phase = 0; m_sent = 0; m_gap = 0; m_valid = 1'b0; m_seen = 1'b0; m_word = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; link = 1'b0; init = 1'b0; s1 = 1'b0; s2 = 1'b0; ready = 1'b0;
    set_creds();
    tick();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data",  data,       32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_done",  32'(done),  32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic vec_t mk(input logic l, input logic i, input logic a, input logic b,
                              input logic r, input logic v, input logic [31:0] d,
                              input logic [1:0] p, input logic dn);
    vec_t t;
    t.link = l; t.init = i; t.s1 = a; t.s2 = b; t.ready = r;
    t.exp_valid = v; t.exp_data = d; t.exp_phase = p; t.exp_done = dn;
    return t;
  endfunction

  // Word = type byte in [31:24], 8-bit header credits at bit 14, 12-bit data credits at bit 0.
  function automatic logic [31:0] exp_word(input int ph_sel, input int k);
    logic [31:0] t;
    t = (ph_sel == 1 ? 32'h40 : 32'hC0) + 32'(16 * k);
    t = t | 32'(VC);
    return (t << 24) | (32'(m_cred[2*k]) << 14) | 32'(m_cred[2*k+1]);
  endfunction

  task automatic model_advance();
    m_phase++; m_sent = 0; m_seen = 1'b0;
  endtask

  task automatic model_step();
    if (!link) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (init) begin
        m_phase = 1; m_sent = 0; m_seen = 1'b0;
        m_cred[0] = int'(ph);   m_cred[1] = int'(pd);
        m_cred[2] = int'(nph);  m_cred[3] = int'(npd);
        m_cred[4] = int'(cplh); m_cred[5] = int'(cpld);
      end
    end else if (m_phase != 3) begin
      m_seen = m_seen | (m_phase == 1 ? s1 : s2);
      if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) begin
          if (m_seen) model_advance();
          else begin m_valid = 1'b1; m_word = exp_word(m_phase, 0); end
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
        m_sent++;
        if (m_sent % 3 == 0) begin
          if (m_seen) model_advance();
`ifdef FC_INIT_RESEND_TIMER_EN
          else m_gap = RESEND;
`endif
        end
      end else if (!m_valid) begin
        m_valid = 1'b1;
        m_word  = exp_word(m_phase, m_sent % 3);
      end
    end
  endtask

  initial begin
    vec_t vecs[$];
    int   low;

    do_reset();

`ifndef FC_INIT_RESEND_TIMER_EN
    // One full FC1 set, a second set with fc1 stored pulsed on NP, then FC2 to done.
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h0, 2'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, P1,    2'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h0, 2'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, NP1,   2'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h0, 2'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, C1,    2'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h0, 2'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, P1,    2'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h0, 2'd1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 1, NP1,   2'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h0, 2'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, C1,    2'd1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h0, 2'd2, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, P2,    2'd2, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 32'h0, 2'd2, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, NP2,   2'd2, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 32'h0, 2'd2, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, C2,    2'd2, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 32'h0, 2'd3, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 32'h0, 2'd3, 1));
    foreach (vecs[i]) begin
      link = vecs[i].link; init = vecs[i].init; s1 = vecs[i].s1; s2 = vecs[i].s2;
      ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].exp_phase));
      check($sformatf("vec%0d_done", i),  32'(done),  32'(vecs[i].exp_done));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end
`endif

    // Backpressure: NP word held stable for 5 stalled cycles, index moves once.
    do_reset();
    link = 1'b1; init = 1'b1; ready = 1'b1;
    tick(); tick(); tick();
    ready = 1'b0;
    tick();
    check("stall_np_valid", 32'(valid), 32'd1);
    check("stall_np_data",  data,       NP1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d_valid", i), 32'(valid), 32'd1);
      check($sformatf("stall%0d_data", i),  data,       NP1);
    end
    ready = 1'b1;
    tick();
    check("stall_hs_valid", 32'(valid), 32'd0);
    tick();
    check("stall_next_valid", 32'(valid), 32'd1);
    check("stall_next_data",  data,       C1);

    // Link drop with an FC2 word pending, then relink restarts at InitFC1-P.
    do_reset();
    link = 1'b1; init = 1'b1; ready = 1'b1; s1 = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("drop_pre_phase", 32'(phase), 32'd2);
    tick();
    s1 = 1'b0;
    check("drop_pre_valid", 32'(valid), 32'd1);
    check("drop_pre_data",  data,       P2);
    link = 1'b0;
    tick();
    check("drop_valid", 32'(valid), 32'd0);
    check("drop_phase", 32'(phase), 32'd0);
    check("drop_done",  32'(done),  32'd0);
    link = 1'b1;
    tick();
    check("relink_phase", 32'(phase), 32'd1);
    check("relink_valid0", 32'(valid), 32'd0);
    tick();
    check("relink_valid1", 32'(valid), 32'd1);
    check("relink_data",   data,       P1);

`ifdef FC_INIT_RESEND_TIMER_EN
    // Exactly RESEND idle cycles between Cpl acceptance and the next P word.
    do_reset();
    link = 1'b1; init = 1'b1; ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    low = 0;
    for (int i = 0; i < 40 && !valid; i++) begin
      low++;
      tick();
    end
    check("gap_cycles", 32'(low), 32'(RESEND));
    check("gap_data",   data,     P1);
    check("gap_phase",  32'(phase), 32'd1);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      link  = ($urandom_range(0, 299) != 0);
      init  = ($urandom_range(0, 3) != 0);
      s1    = ($urandom_range(0, 11) == 0);
      s2    = ($urandom_range(0, 11) == 0);
      ready = ($urandom_range(0, 2) != 0);
      ph    = 8'($urandom);  pd   = 12'($urandom);
      nph   = 8'($urandom);  npd  = 12'($urandom);
      cplh  = 8'($urandom);  cpld = 12'($urandom);
      model_step();
      tick();
      check("rnd_valid", 32'(valid), 32'(m_valid));
      check("rnd_phase", 32'(phase), 32'(m_phase));
      check("rnd_done",  32'(done),  32'(m_phase == 3));
      if (m_valid) check("rnd_data", data, m_word);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule
